// File: rtl/nrf_pkg.sv
// Shared definitions for the nRF24L01 SPI master and its users.
package nrf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } nrf_state_e;

  // 1 command byte + 32 payload bytes
  localparam int NRF_MAX_LEN = 33;

  // nRF24L01 command bytes
  localparam logic [7:0] R_REGISTER   = 8'h00;
  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] FLUSH_RX     = 8'hE2;
  localparam logic [7:0] NOP          = 8'hFF;

  // A transaction length is usable when it is 1..max_len
  function automatic logic len_ok(input logic [5:0] l, input int max_len);
    return (l != 6'd0) && (int'(l) <= max_len);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase timer: strobes the cycle before each SCK edge.
// Both strobes are only produced while en_i is high; the counter restarts
// from zero whenever en_i drops so every SHIFT entry begins a fresh low phase.
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_10,
  input  logic rst,
  input  logic en_i,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0] div_q;
  logic       phase_q;   // 0: low half, 1: high half
  logic       tc;

  assign tc = (div_q == DIV_TC);

  // Count CLK_DIV cycles per half period and flip phase at terminal count
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      div_q   <= 8'd0;
      phase_q <= 1'b0;
    end else if (!en_i) begin
      div_q   <= 8'd0;
      phase_q <= 1'b0;
    end else if (tc) begin
      div_q   <= 8'd0;
      phase_q <= ~phase_q;
    end else begin
      div_q   <= div_q + 8'd1;
    end
  end

  assign sck_rise_o = en_i & tc & ~phase_q;
  assign sck_fall_o = en_i & tc &  phase_q;

endmodule

// File: rtl/nrf_spi_master.sv
// Multi-byte SPI mode-0 master for the nRF24L01: frames one CSN-low burst of
// len bytes, MSB first, pulling each byte from upstream via tx_ack.
import nrf_pkg::*;

module nrf_spi_master #(
  parameter int CLK_DIV   = 1,
  parameter int CSN_SETUP = 1,
  parameter int CSN_HOLD  = 1,
  parameter int MAX_LEN   = NRF_MAX_LEN
) (
  input  logic       clk_10,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] len,
  input  logic [7:0] tx_byte,
  output logic       tx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       csn,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  nrf_state_e state_q;
  logic       csn_q, sck_q, rx_valid_q, done_q, busy_q;
  logic [7:0] rx_byte_q, tx_sreg_q, rx_sreg_q;
  logic [2:0] bit_cnt_q;
  logic [5:0] byte_cnt_q;
  logic [3:0] wait_cnt_q;

  logic sck_rise, sck_fall;
  logic start_ok, byte_end, more_bytes;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_10     (clk_10),
    .rst        (rst),
    .en_i       (state_q == ST_SHIFT),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  assign start_ok   = (state_q == ST_IDLE) && start && len_ok(len, MAX_LEN);
  assign byte_end   = sck_fall && (bit_cnt_q == 3'd7);
  assign more_bytes = (byte_cnt_q != 6'd1);

  // tx_ack marks the cycle whose closing edge loads tx_byte into the shift
  // register: the accepting start cycle, and the last high-phase cycle of
  // every byte that is followed by another one.
  assign tx_ack = start_ok || (byte_end && more_bytes);

  // Transaction sequencer: CSN framing, bit/byte counting and data shifting
  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      csn_q      <= 1'b1;
      sck_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_byte_q  <= 8'h00;
      tx_sreg_q  <= 8'h00;
      rx_sreg_q  <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 6'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            byte_cnt_q <= len;
            tx_sreg_q  <= tx_byte;
            bit_cnt_q  <= 3'd0;
            wait_cnt_q <= 4'd0;
            csn_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SETUP;
          end else if (start) begin
            // Unusable length: report completion without touching the bus
            done_q     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (wait_cnt_q == 4'(CSN_SETUP - 1)) begin
            wait_cnt_q <= 4'd0;
            state_q    <= ST_SHIFT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sck_q     <= 1'b1;
            rx_sreg_q <= {rx_sreg_q[6:0], miso};
          end
          if (sck_fall) begin
            sck_q     <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_end) begin
              rx_byte_q  <= rx_sreg_q;
              rx_valid_q <= 1'b1;
              if (more_bytes) begin
                byte_cnt_q <= byte_cnt_q - 6'd1;
                tx_sreg_q  <= tx_byte;
              end else begin
                tx_sreg_q  <= 8'h00;
                state_q    <= ST_HOLD;
              end
            end else begin
              tx_sreg_q <= {tx_sreg_q[6:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (wait_cnt_q == 4'(CSN_HOLD - 1)) begin
            wait_cnt_q <= 4'd0;
            csn_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign csn      = csn_q;
  assign sck      = sck_q;
  assign mosi     = tx_sreg_q[7];
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nrf_spi_master.sv
// Directed bench for nrf_spi_master: CLK_DIV=1 instance plus a CLK_DIV=3 one.
module tb_nrf_spi_master;

  logic       clk_10 = 1'b0;
  logic       rst    = 1'b1;
  logic       start, tx_ack, rx_valid, busy, done, csn, sck, mosi, miso;
  logic [5:0] len;
  logic [7:0] tx_byte, rx_byte;

  logic       d3_start, d3_tx_ack, d3_rx_valid, d3_busy, d3_done, d3_csn, d3_sck, d3_mosi, d3_miso;
  logic [5:0] d3_len;
  logic [7:0] d3_tx_byte, d3_rx_byte;

  always #5 clk_10 = ~clk_10;

  nrf_spi_master dut (
    .clk_10(clk_10), .rst(rst), .start(start), .len(len), .tx_byte(tx_byte),
    .tx_ack(tx_ack), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .done(done), .csn(csn), .sck(sck), .mosi(mosi), .miso(miso)
  );

  nrf_spi_master #(.CLK_DIV(3)) dut3 (
    .clk_10(clk_10), .rst(rst), .start(d3_start), .len(d3_len), .tx_byte(d3_tx_byte),
    .tx_ack(d3_tx_ack), .rx_byte(d3_rx_byte), .rx_valid(d3_rx_valid), .busy(d3_busy),
    .done(d3_done), .csn(d3_csn), .sck(d3_sck), .mosi(d3_mosi), .miso(d3_miso)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction stimulus data and observations
  logic [7:0] txd [0:40];
  logic [7:0] sld [0:40];
  logic [7:0] rxg [0:40];
  logic [7:0] mcap[0:40];
  int ack_c[0:40], rxv_c[0:40];
  int ack_n, rxv_n, done_n, done_c, csn_first, csn_last, busy_first, busy_last;
  int rises, per_err, mosi_err;

  // Start at cycle 0, serve tx bytes on tx_ack, act as mode-0 slave, log events.
  // dup_at: cycle of a second (ignored) start; rst_at: cycle of an async reset.
  task automatic run_txn(input logic [5:0] l, input int dup_at, input int rst_at, input int max_cyc);
    int c, last_rise;
    logic p_sck, p_mosi;
    logic [7:0] sh;
    ack_n = 0; rxv_n = 0; done_n = 0; done_c = -1;
    csn_first = -1; csn_last = -1; busy_first = -1; busy_last = -1;
    rises = 0; per_err = 0; mosi_err = 0;
    last_rise = -1; p_sck = 1'b0; p_mosi = 1'b0; sh = 8'h00; c = 0;
    @(posedge clk_10); #1;
    start = 1'b1; len = l; tx_byte = txd[0]; miso = sld[0][7];
    while (c <= max_cyc) begin
      @(negedge clk_10);
      if (tx_ack) begin if (ack_n <= 40) ack_c[ack_n] = c; ack_n++; end
      if (rx_valid) begin
        if (rxv_n <= 40) begin rxv_c[rxv_n] = c; rxg[rxv_n] = rx_byte; end
        rxv_n++;
      end
      if (done) begin done_c = c; done_n++; end
      if (!csn) begin if (csn_first < 0) csn_first = c; csn_last = c; end
      if (busy) begin if (busy_first < 0) busy_first = c; busy_last = c; end
      if (sck && !p_sck) begin
        sh = {sh[6:0], mosi};
        rises++;
        if (rises % 8 == 0 && rises / 8 <= 41) mcap[rises/8 - 1] = sh;
        if (last_rise >= 0 && c - last_rise != 2) per_err++;
        last_rise = c;
      end
      if (sck && mosi !== p_mosi) mosi_err++;
      p_sck = sck; p_mosi = mosi;
      @(posedge clk_10); #1;
      c++;
      start = (c == dup_at);
      if (c == dup_at) len = 6'd1;
      tx_byte = txd[(ack_n <= 40) ? ack_n : 40];
      miso = sld[(rises / 8) % 41][7 - (rises % 8)];
      if (rst_at >= 0 && c == rst_at) begin
        chk("pre_rst_sck", 32'(sck), 1);
        chk("pre_rst_mosi", 32'(mosi), 1);
        rst = 1'b1;
        #1;
        chk("rst_csn", 32'(csn), 1);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
      end
      if (rst_at >= 0 && c == rst_at + 2) rst = 1'b0;
    end
    start = 1'b0;
  endtask

  int bad;

  initial begin
    start = 0; len = 0; tx_byte = 0; miso = 0;
    d3_start = 0; d3_len = 0; d3_tx_byte = 0; d3_miso = 0;
    for (int i = 0; i <= 40; i++) begin txd[i] = 8'h00; sld[i] = 8'h00; end
    repeat (3) @(posedge clk_10);
    @(negedge clk_10);
    chk("reset_csn", 32'(csn), 1);
    chk("reset_sck", 32'(sck), 0);
    chk("reset_mosi", 32'(mosi), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_byte", 32'(rx_byte), 0);
    chk("reset_tx_ack", 32'(tx_ack), 0);
    chk("reset_d3_csn", 32'(d3_csn), 1);
    @(posedge clk_10); #1 rst = 1'b0;
    repeat (2) @(posedge clk_10);

    // Single NOP, slave answers STATUS 0x0E
    txd[0] = 8'hFF; sld[0] = 8'h0E;
    run_txn(6'd1, -1, -1, 24);
    chk("nop_mosi", 32'(mcap[0]), 32'hFF);
    chk("nop_rx_byte", 32'(rxg[0]), 32'h0E);
    chk("nop_rx_valid_cyc", rxv_c[0], 18);
    chk("nop_rx_valid_n", rxv_n, 1);
    chk("nop_done_cyc", done_c, 19);
    chk("nop_done_n", done_n, 1);
    chk("nop_csn_first", csn_first, 1);
    chk("nop_csn_last", csn_last, 18);
    chk("nop_busy_first", busy_first, 1);
    chk("nop_busy_last", busy_last, 19);
    chk("nop_ack", ack_n, 1);
    chk("nop_ack_cyc", ack_c[0], 0);
    chk("nop_rises", rises, 8);
    chk("nop_sck_period", per_err, 0);

    // Register write: W_REGISTER|0x00 then 0x0B. Byte 1 is fetched in the last
    // high-phase cycle of byte 0 (cycle 17), loaded on the edge sck falls.
    txd[0] = 8'h20; txd[1] = 8'h0B; sld[0] = 8'h0E; sld[1] = 8'h55;
    run_txn(6'd2, -1, -1, 40);
    chk("wr_ack_n", ack_n, 2);
    chk("wr_ack1_cyc", ack_c[1], 17);
    chk("wr_slave_b0", 32'(mcap[0]), 32'h20);
    chk("wr_slave_b1", 32'(mcap[1]), 32'h0B);
    chk("wr_rx_n", rxv_n, 2);
    chk("wr_rx0", 32'(rxg[0]), 32'h0E);
    chk("wr_rx1", 32'(rxg[1]), 32'h55);
    chk("wr_rx1_cyc", rxv_c[1], 34);
    chk("wr_done_cyc", done_c, 35);
    chk("wr_csn_last", csn_last, 34);
    chk("wr_mosi_stable", mosi_err, 0);

    // Full payload: W_TX_PAYLOAD + 32 incrementing bytes
    txd[0] = 8'hA0; sld[0] = 8'h0E;
    for (int i = 1; i <= 32; i++) begin txd[i] = 8'(i); sld[i] = 8'(8'h80 ^ i); end
    run_txn(6'd33, -1, -1, 540);
    chk("full_ack_n", ack_n, 33);
    chk("full_rx_n", rxv_n, 33);
    bad = 0;
    for (int i = 0; i < 33; i++) if (mcap[i] !== txd[i] || rxg[i] !== sld[i]) bad++;
    chk("full_data", bad, 0);
    bad = 0;
    for (int i = 1; i < 33; i++) if (rxv_c[i] - rxv_c[i-1] != 16) bad++;
    for (int i = 2; i < 33; i++) if (ack_c[i] - ack_c[i-1] != 16) bad++;
    chk("full_byte_spacing", bad, 0);
    chk("full_sck_period", per_err, 0);
    chk("full_rises", rises, 264);
    chk("full_done_cyc", done_c, 531);
    chk("full_mosi_stable", mosi_err, 0);

    // Boundary lengths
    run_txn(6'd0, -1, -1, 6);
    chk("len0_done_cyc", done_c, 1);
    chk("len0_done_n", done_n, 1);
    chk("len0_csn", csn_first, -1);
    chk("len0_busy", busy_first, -1);
    chk("len0_ack", ack_n, 0);
    run_txn(6'd34, -1, -1, 6);
    chk("len34_done_cyc", done_c, 1);
    chk("len34_csn", csn_first, -1);
    chk("len34_busy", busy_first, -1);
    chk("len34_ack", ack_n, 0);

    // Start while busy is ignored
    txd[0] = 8'h20; txd[1] = 8'h0B; sld[0] = 8'h0E; sld[1] = 8'h55;
    run_txn(6'd2, 5, -1, 70);
    chk("busy_done_n", done_n, 1);
    chk("busy_done_cyc", done_c, 35);
    chk("busy_rx_n", rxv_n, 2);
    chk("busy_ack_n", ack_n, 2);

    // Reset during bit 4 of byte 1 (its high phase is cycle 25)
    txd[0] = 8'h20; txd[1] = 8'hFF;
    run_txn(6'd2, -1, 25, 45);
    chk("rst_done_n", done_n, 0);
    chk("rst_csn_last", csn_last, 24);
    txd[0] = 8'hFF; sld[0] = 8'h0E;
    run_txn(6'd1, -1, -1, 24);
    chk("post_rst_done_cyc", done_c, 19);
    chk("post_rst_rx", 32'(rxg[0]), 32'h0E);
    chk("post_rst_mosi", 32'(mcap[0]), 32'hFF);

    // CLK_DIV=3: 3-cycle phases, miso inverted except on the sampling cycle
    begin
      int c, b, r3, sck_bad, d3c, rv3c;
      logic [7:0] pat, sh3, rx3;
      logic p3, exp_sck;
      pat = 8'hA5; sh3 = 8'h00; rx3 = 8'h00; p3 = 1'b0;
      r3 = 0; sck_bad = 0; d3c = -1; rv3c = -1; c = 0;
      @(posedge clk_10); #1;
      d3_start = 1'b1; d3_len = 6'd1; d3_tx_byte = 8'h3C; d3_miso = 1'b0;
      while (c <= 60) begin
        @(negedge clk_10);
        exp_sck = (c >= 2 && c < 50 && ((c - 2) % 6) >= 3);
        if (d3_sck !== exp_sck) sck_bad++;
        if (d3_sck && !p3) begin sh3 = {sh3[6:0], d3_mosi}; r3++; end
        if (d3_done) d3c = c;
        if (d3_rx_valid) begin rv3c = c; rx3 = d3_rx_byte; end
        p3 = d3_sck;
        @(posedge clk_10); #1;
        c++;
        d3_start = 1'b0;
        if (c >= 2 && c < 50) begin
          b = (c - 2) / 6;
          d3_miso = (c == 4 + 6 * b) ? pat[7 - b] : ~pat[7 - b];
        end else begin
          d3_miso = 1'b0;
        end
      end
      chk("div3_sck_phases", sck_bad, 0);
      chk("div3_rises", r3, 8);
      chk("div3_mosi", 32'(sh3), 32'h3C);
      chk("div3_rx_byte", 32'(rx3), 32'hA5);
      chk("div3_rx_valid_cyc", rv3c, 50);
      chk("div3_done_cyc", d3c, 51);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
